// File: rtl/axi_mst_pkg.sv
// axi_mst_pkg: shared FSM states and AXI encodings for the read master.
package axi_mst_pkg;
  typedef enum logic [3:0] {
    ST_INIT, ST_TRIGGER, ST_READ_REGS, ST_INIT_ADDR, ST_NBURST,
    ST_ADDR, ST_DATA, ST_INCR_ADDR, ST_TRIGGER_END, ST_END
  } rd_state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic logic [2:0] axsize(input int unsigned bytes);
    axsize = 3'd0;
    for (int i = 0; i < 8; i++) if (bytes == (32'd1 << i)) axsize = 3'(i);
  endfunction
endpackage

// File: rtl/fifo_axi_cnt.sv
// fifo_axi_cnt: single-clock FIFO with occupancy count; push on full is taken when a pop coincides.
module fifo_axi_cnt #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push, pop;
  assign empty_o = cnt_q == '0;
  assign pop = pop_i & !empty_o;
  assign push = push_i & (cnt_q != CW'(DEPTH) | pop);
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/synchronizer_n.sv
// synchronizer_n: N-flop resynchroniser for asynchronous level inputs.
module synchronizer_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync_q <= '0;
    else sync_q <= {sync_q[N-2:0], d_i};
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/axi_mst_read.sv
// axi_mst_read: AXI3 burst read master streaming beats out over AXIS.
// AXI_MST_READ_RESP_CHECK_EN enables counting of beats with a non-OKAY RRESP.
module axi_mst_read
  import axi_mst_pkg::*;
#(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_LENGTH   = 7,
  parameter int B_BURST_LENGTH = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      trigger,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [31:0]               m_axi_araddr,
  output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [1:0]                m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      START_REG,
  input  logic [31:0]               ADDR_REG,
  input  logic [31:0]               NBURST_REG,
  output logic [31:0]               ERR_CNT_REG
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [B_BURST_LENGTH-1:0] LEN = B_BURST_LENGTH'(BURST_LENGTH);
  localparam logic [CW-1:0] MAX_FILL = CW'(FIFO_DEPTH - BURST_LENGTH - 1);
  localparam logic [31:0] BURST_BYTES = 32'((BURST_LENGTH + 1) * (DATA_WIDTH / 8));
  rd_state_t state_q;
  logic [31:0] addr_q, addr_r_q, nburst_q, cnt_nburst_q;
  logic [B_BURST_LENGTH-1:0] cnt_beat_q;
  logic arvalid_q, rready_q, start_s, trig_s, r_hs, burst_done, is_last, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [DATA_WIDTH:0] fifo_dout;
  synchronizer_n u_sync_start (.clk(clk), .rstn(rstn), .d_i(START_REG), .q_o(start_s));
  synchronizer_n u_sync_trig (.clk(clk), .rstn(rstn), .d_i(trigger), .q_o(trig_s));
  assign r_hs = m_axi_rvalid & rready_q;
  // RLAST ends the burst, but the beat count also caps it so a missing RLAST cannot hang us
  assign burst_done = r_hs & (m_axi_rlast | cnt_beat_q == LEN);
  assign is_last = burst_done & (cnt_nburst_q + 32'd1 == nburst_q);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_INIT;
      addr_q <= '0;
      addr_r_q <= '0;
      nburst_q <= '0;
      cnt_nburst_q <= '0;
      cnt_beat_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: if (start_s) state_q <= ST_TRIGGER;
        ST_TRIGGER: if (trig_s) state_q <= ST_READ_REGS;
        ST_READ_REGS: begin
          addr_r_q <= ADDR_REG;
          nburst_q <= NBURST_REG;
          cnt_nburst_q <= '0;
          state_q <= ST_INIT_ADDR;
        end
        ST_INIT_ADDR: begin
          addr_q <= addr_r_q;
          state_q <= ST_NBURST;
        end
        ST_NBURST:
          if (cnt_nburst_q == nburst_q) state_q <= ST_TRIGGER_END;
          else if (fifo_cnt <= MAX_FILL) begin
            arvalid_q <= 1'b1;
            state_q <= ST_ADDR;
          end
        ST_ADDR:
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q <= 1'b1;
            cnt_beat_q <= '0;
            state_q <= ST_DATA;
          end
        ST_DATA:
          if (burst_done) begin
            rready_q <= 1'b0;
            cnt_nburst_q <= cnt_nburst_q + 32'd1;
            state_q <= ST_INCR_ADDR;
          end else if (r_hs) cnt_beat_q <= cnt_beat_q + B_BURST_LENGTH'(1);
        ST_INCR_ADDR: begin
          addr_q <= addr_q + BURST_BYTES;
          state_q <= ST_NBURST;
        end
        ST_TRIGGER_END: if (!trig_s) state_q <= ST_END;
        ST_END: if (!start_s) state_q <= ST_INIT;
        default: state_q <= ST_INIT;
      endcase
    end
  fifo_axi_cnt #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn),
    .push_i(r_hs), .data_i({is_last, m_axi_rdata}),
    .pop_i(m_axis_tready), .data_o(fifo_dout),
    .empty_o(fifo_empty), .count_o(fifo_cnt)
  );
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata = m_axis_tvalid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & fifo_dout[DATA_WIDTH];
  assign m_axi_arid = '0;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = LEN;
  assign m_axi_arsize = axsize(DATA_WIDTH / 8);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock = '0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot = 3'b010;
  assign m_axi_arqos = '0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready = rready_q;
`ifdef AXI_MST_READ_RESP_CHECK_EN
  logic [31:0] err_q;
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err_q <= '0;
    else if (state_q == ST_READ_REGS) err_q <= '0;
    else if (r_hs && m_axi_rresp != AXI_RESP_OKAY && err_q != '1) err_q <= err_q + 32'd1;
  assign ERR_CNT_REG = err_q;
`else
  logic unused_r;
  assign unused_r = ^{m_axi_rid, m_axi_rresp};
  assign ERR_CNT_REG = '0;
`endif
endmodule

// File: tb/tb_axi_mst_read.sv
// tb_axi_mst_read: directed bench with an AXI3 read slave model and an AXIS sink.
module tb_axi_mst_read;
  import axi_mst_pkg::*;
`ifdef AXI_MST_READ_RESP_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif
  logic clk = 1'b0, rstn = 1'b0, trigger = 1'b0, START_REG = 1'b0;
  logic [31:0] ADDR_REG = '0, NBURST_REG = '0;
  logic [5:0] m_axi_arid, m_axi_rid;
  logic [31:0] m_axi_araddr, ERR_CNT_REG;
  logic [3:0] m_axi_arlen, m_axi_arcache, m_axi_arqos;
  logic [2:0] m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_arburst, m_axi_arlock, m_axi_rresp;
  logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_rdata, m_axis_tdata;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
  int n_chk = 0, n_err = 0;
  int beat, ar_wait, ar_delay, r_total, r_fires, t_fires, max_lvl, arv_cycles, early_rr, addr_unstable;
  bit ar_fire, r_fire, t_fire, prev_arv, err_en, sink_rdy;
  logic [31:0] prev_araddr, ar_fire_addr;
  logic [31:0] bq[$], ar_addrs[$];
  logic [63:0] got_d[$];
  logic got_l[$];
  always #5 clk = ~clk;
  axi_mst_read dut (
    .clk(clk), .rstn(rstn), .trigger(trigger),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .START_REG(START_REG), .ADDR_REG(ADDR_REG),
    .NBURST_REG(NBURST_REG), .ERR_CNT_REG(ERR_CNT_REG)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // slave + sink: decide at negedge, handshakes land on the following posedge
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
    m_axi_rresp = 0; m_axi_rid = '0; m_axis_tready = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bq.delete(); beat = 0; ar_wait = 0; ar_fire = 0; r_fire = 0; t_fire = 0; prev_arv = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axis_tready = 0;
      end else begin
        if (ar_fire) begin bq.push_back(ar_fire_addr); ar_addrs.push_back(ar_fire_addr); end
        if (r_fire) begin
          r_fires++; r_total++;
          if (beat == 7) begin beat = 0; bq.delete(0); end else beat++;
        end
        if (t_fire) t_fires++;
        if (r_fires - t_fires > max_lvl) max_lvl = r_fires - t_fires;
        if (prev_arv && (!m_axi_arvalid || m_axi_araddr != prev_araddr)) addr_unstable++;
        if (m_axi_arvalid) arv_cycles++;
        m_axi_arready = m_axi_arvalid && ar_wait >= ar_delay;
        if (!m_axi_arvalid || m_axi_arready) ar_wait = 0; else ar_wait++;
        ar_fire = m_axi_arvalid && m_axi_arready;
        ar_fire_addr = m_axi_araddr;
        prev_arv = m_axi_arvalid && !m_axi_arready;
        prev_araddr = m_axi_araddr;
        if (m_axi_rready && bq.size() == 0) early_rr++;
        if (bq.size() != 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata = {32'hCAFE0000 + 32'(beat), bq[0] + 32'(beat * 8)};
          m_axi_rlast = beat == 7;
          m_axi_rresp = (err_en && r_total == 2) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        end
        r_fire = m_axi_rvalid && m_axi_rready;
        m_axis_tready = sink_rdy;
        t_fire = m_axis_tvalid && m_axis_tready;
        if (t_fire) begin got_d.push_back(m_axis_tdata); got_l.push_back(m_axis_tlast); end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic start_run(input logic [31:0] addr, input logic [31:0] nb);
    ADDR_REG = addr; NBURST_REG = nb;
    got_d.delete(); got_l.delete(); ar_addrs.delete();
    r_total = 0; r_fires = 0; t_fires = 0; max_lvl = 0; arv_cycles = 0; early_rr = 0; addr_unstable = 0;
    START_REG = 1; tick(5); trigger = 1;
  endtask
  task automatic end_run;
    trigger = 0; tick(5); START_REG = 0; tick(5);
  endtask
  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (got_d.size() < n && c < budget) begin tick(1); c++; end
    chk("beat_count", 64'(got_d.size()), 64'(n));
  endtask
  task automatic check_stream(input string tag, input logic [31:0] addr, input int nb);
    chk({tag, "_ar_cnt"}, 64'(ar_addrs.size()), 64'(nb));
    for (int b = 0; b < nb; b++)
      chk({tag, "_araddr"}, (b < ar_addrs.size()) ? 64'(ar_addrs[b]) : 64'hDEAD, 64'(addr + 32'(b * 64)));
    for (int i = 0; i < nb * 8; i++) begin
      chk({tag, "_data"}, (i < got_d.size()) ? got_d[i] : 64'hDEAD,
          {32'hCAFE0000 + 32'(i % 8), addr + 32'(i * 8)});
      chk({tag, "_tlast"}, (i < got_l.size()) ? 64'(got_l[i]) : 64'hDEAD, 64'(i == nb * 8 - 1));
    end
  endtask
  initial begin
    ar_delay = 0; err_en = 0; sink_rdy = 1;
    tick(3);
    chk("rst_arvalid", 64'(m_axi_arvalid), 0);
    chk("rst_rready", 64'(m_axi_rready), 0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_araddr", 64'(m_axi_araddr), 0);
    chk("rst_err", 64'(ERR_CNT_REG), 0);
    chk("arlen", 64'(m_axi_arlen), 7);
    chk("arsize", 64'(m_axi_arsize), 3);
    chk("arburst", 64'(m_axi_arburst), 1);
    chk("arprot", 64'(m_axi_arprot), 2);
    rstn = 1; tick(3);
    chk("rst_state", 64'(dut.state_q), 64'(ST_INIT));
    // basic run
    start_run(32'h1000, 2);
    wait_beats(16, 400);
    check_stream("basic", 32'h1000, 2);
    chk("basic_arv_cycles", 64'(arv_cycles), 2);
    end_run;
    chk("basic_init", 64'(dut.state_q), 64'(ST_INIT));
    // delayed ARREADY
    ar_delay = 5;
    start_run(32'h2000, 1);
    wait_beats(8, 400);
    check_stream("ardly", 32'h2000, 1);
    chk("ardly_arv_cycles", 64'(arv_cycles), 6);
    chk("ardly_stable", 64'(addr_unstable), 0);
    chk("ardly_early_rready", 64'(early_rr), 0);
    end_run;
    ar_delay = 0;
    // zero bursts
    start_run(32'h7000, 0);
    tick(30);
    chk("nb0_ar_cnt", 64'(ar_addrs.size()), 0);
    chk("nb0_arv_cycles", 64'(arv_cycles), 0);
    chk("nb0_tvalid", 64'(m_axis_tvalid), 0);
    trigger = 0; tick(6);
    chk("nb0_end", 64'(dut.state_q), 64'(ST_END));
    START_REG = 0; tick(6);
    chk("nb0_init", 64'(dut.state_q), 64'(ST_INIT));
    // backpressure
    sink_rdy = 0;
    start_run(32'h3000, 4);
    tick(150);
    chk("bp_ar_held", 64'(ar_addrs.size()), 2);
    chk("bp_level", 64'(r_fires - t_fires), 16);
    chk("bp_tvalid", 64'(m_axis_tvalid), 1);
    sink_rdy = 1;
    wait_beats(32, 600);
    check_stream("bp", 32'h3000, 4);
    chk("bp_max_level", 64'(max_lvl), 16);
    end_run;
    // error response on third beat
    err_en = 1;
    start_run(32'h4000, 1);
    wait_beats(8, 400);
    check_stream("resp", 32'h4000, 1);
    end_run;
    chk("resp_err_cnt", 64'(ERR_CNT_REG), 64'(EXP_ERR));
    err_en = 0;
    // async reset in the middle of a burst
    start_run(32'h6000, 4);
    begin
      int c = 0;
      while (got_d.size() < 3 && c < 400) begin tick(1); c++; end
    end
    chk("mid_rready_before", 64'(m_axi_rready), 1);
    #2 rstn = 0;
    #1;
    chk("mid_arvalid", 64'(m_axi_arvalid), 0);
    chk("mid_rready", 64'(m_axi_rready), 0);
    chk("mid_tvalid", 64'(m_axis_tvalid), 0);
    chk("mid_tdata", m_axis_tdata, 0);
    chk("mid_tlast", 64'(m_axis_tlast), 0);
    chk("mid_araddr", 64'(m_axi_araddr), 0);
    chk("mid_err", 64'(ERR_CNT_REG), 0);
    trigger = 0; START_REG = 0;
    tick(3); rstn = 1; tick(3);
    start_run(32'h5000, 1);
    wait_beats(8, 400);
    check_stream("rerun", 32'h5000, 1);
    end_run;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
